// File: rtl/aib_rx_word_aligner.sv
// AIB receive word aligner for 2:1-mode words.
// Finds the half-word boundary with marker bits (bit 79 = 1, bit 39 = 0),
// locks after LOCK_CNT consecutive hits, and drops lock after UNLOCK_CNT
// consecutive misses. Markers are stripped from the 78-bit output payload.
module aib_rx_word_aligner #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        align_en_i,
  input  logic        rx_valid_i,
  input  logic [79:0] rx_data_i,
  output logic [77:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        offset_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_CNT_W   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_CNT_W = 8'(UNLOCK_CNT);

  state_t      r_state;
  logic [39:0] r_prev_hi;   // only the upper half of the last word feeds candidate B
  logic        r_prev_ok;
  logic [7:0]  r_hit_cnt;
  logic [7:0]  r_miss_cnt;
  logic [7:0]  r_err_cnt;
  logic        r_offset;
  logic        r_locked;
  logic        r_valid;
  logic [77:0] r_data;

  logic [79:0] w_cand_a;
  logic [79:0] w_cand_b;
  logic [79:0] w_sel;
  logic        w_match_a;
  logic        w_match_b;
  logic        w_match_sel;
  logic [7:0]  w_hit_inc;
  logic [7:0]  w_miss_inc;

  // Candidate words, marker detection and counter increments
  always_comb begin
    w_cand_a    = rx_data_i;
    w_cand_b    = {rx_data_i[39:0], r_prev_hi};
    w_sel       = r_offset ? w_cand_b : w_cand_a;
    w_match_a   = w_cand_a[79] & ~w_cand_a[39];
    w_match_b   = w_cand_b[79] & ~w_cand_b[39];
    w_match_sel = w_sel[79] & ~w_sel[39];
    w_hit_inc   = r_hit_cnt + 8'd1;
    w_miss_inc  = r_miss_cnt + 8'd1;
  end

  // Alignment FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prev_hi  <= '0;
      r_prev_ok  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_err_cnt  <= '0;
      r_offset   <= 1'b0;
      r_locked   <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (rx_valid_i) begin
        r_prev_hi <= rx_data_i[79:40];
      end
      if (!align_en_i) begin
        r_state    <= IDLE;
        r_prev_ok  <= 1'b0;
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
        r_err_cnt  <= '0;
        r_locked   <= 1'b0;
      end else if (r_state == IDLE) begin
        r_state <= SEARCH;
      end else if (rx_valid_i) begin
        r_prev_ok <= 1'b1;
        case (r_state)
          SEARCH: begin
            if (w_match_a) begin
              r_state   <= VERIFY;
              r_offset  <= 1'b0;
              r_hit_cnt <= 8'd1;
            end else if (w_match_b && r_prev_ok) begin
              r_state   <= VERIFY;
              r_offset  <= 1'b1;
              r_hit_cnt <= 8'd1;
            end
          end
          VERIFY: begin
            if (w_match_sel) begin
              r_hit_cnt <= w_hit_inc;
              if (w_hit_inc == LOCK_CNT_W) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_state   <= SEARCH;
              r_hit_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_match_sel) begin
              r_miss_cnt <= '0;
              r_valid    <= 1'b1;
              r_data     <= {w_sel[78:40], w_sel[38:0]};
            end else begin
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
              if (w_miss_inc == UNLOCK_CNT_W) begin
                r_state    <= SEARCH;
                r_miss_cnt <= '0;
                r_hit_cnt  <= '0;
                r_locked   <= 1'b0;
              end else begin
                r_miss_cnt <= w_miss_inc;
                r_valid    <= 1'b1;
                r_data     <= {w_sel[78:40], w_sel[38:0]};
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign locked_o  = r_locked;
  assign offset_o  = r_offset;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_aib_rx_word_aligner.sv
// Directed bench for aib_rx_word_aligner with a scoreboard of expected
// output payloads popped by an independent monitor.
module tb_aib_rx_word_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        align_en_i;
  logic        rx_valid_i;
  logic [79:0] rx_data_i;
  logic [77:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        offset_o;
  logic [7:0]  err_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [77:0] exp_q[$];

  aib_rx_word_aligner #(.LOCK_CNT(8), .UNLOCK_CNT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .align_en_i (align_en_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .locked_o   (locked_o),
    .offset_o   (offset_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Aligned word: marker 1 in bit 79, marker 0 in bit 39
  function automatic logic [79:0] good(input int n);
    return {1'b1, 39'(n + 32'h100), 1'b0, 39'(n)};
  endfunction

  // Word whose upper marker is wrong
  function automatic logic [79:0] bad(input int n);
    return {1'b0, 39'(n + 32'h200), 1'b0, 39'(n)};
  endfunction

  // Aligned stream delivered shifted by one half-word
  function automatic logic [79:0] raw_sw(input int k);
    logic [79:0] t;
    logic [79:0] tp;
    t  = good(k);
    tp = good(k - 1);
    return {t[39:0], tp[79:40]};
  endfunction

  function automatic logic [77:0] strip(input logic [79:0] w);
    return {w[78:40], w[38:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [79:0] w);
    rx_valid_i = 1'b1;
    rx_data_i  = w;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart();
    align_en_i = 1'b0;
    idle(1);
    align_en_i = 1'b1;
    idle(1);
  endtask

  // Monitor: every presented output word must match the scoreboard head
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_valid: got data_o %h expected no output", data_o);
      end else begin
        chk("data_o", {2'b00, data_o}, {2'b00, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    align_en_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;

    // Reset with random traffic
    for (int i = 0; i < 2; i++) begin
      rx_valid_i = 1'($urandom);
      rx_data_i  = {$urandom, $urandom, 16'($urandom)};
      tick();
    end
    chk("rst_data_o", {2'b00, data_o}, '0);
    chk("rst_valid_o", {79'd0, valid_o}, '0);
    chk("rst_locked_o", {79'd0, locked_o}, '0);
    chk("rst_offset_o", {79'd0, offset_o}, '0);
    chk("rst_err_cnt_o", {72'd0, err_cnt_o}, '0);

    // Aligned stream: lock after 8th word, 9th word output one cycle later
    rst_n = 1'b1;
    idle(1);
    for (int n = 1; n <= 8; n++) begin
      send(good(n));
      chk("aligned_locked_o", {79'd0, locked_o}, {79'd0, n == 8});
    end
    chk("aligned_offset_o", {79'd0, offset_o}, '0);
    exp_q.push_back(strip(good(9)));
    send(good(9));
    chk("first_out_latency", {79'd0, valid_o}, 80'd1);
    exp_q.push_back(strip(good(10)));
    send(good(10));

    // Three misses then a hit: lock held, err=3
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(strip(bad(k)));
      send(bad(k));
    end
    exp_q.push_back(strip(good(11)));
    send(good(11));
    chk("miss3_locked_o", {79'd0, locked_o}, 80'd1);
    chk("miss3_err_cnt_o", {72'd0, err_cnt_o}, 80'd3);

    // Four misses: unlock, err=7, fourth word not output
    for (int k = 0; k < 4; k++) begin
      if (k < 3) exp_q.push_back(strip(bad(10 + k)));
      send(bad(10 + k));
      chk("unlock_locked_o", {79'd0, locked_o}, {79'd0, k != 3});
    end
    chk("unlock_err_cnt_o", {72'd0, err_cnt_o}, 80'd7);
    chk("unlock_no_output", {79'd0, valid_o}, '0);
    idle(1);

    // Enable dropped at hit_cnt=5, then a full fresh relock
    for (int n = 20; n < 25; n++) begin
      send(good(n));
      chk("verify5_locked_o", {79'd0, locked_o}, '0);
    end
    align_en_i = 1'b0;
    idle(1);
    chk("disable_err_cnt_o", {72'd0, err_cnt_o}, '0);
    chk("disable_locked_o", {79'd0, locked_o}, '0);
    align_en_i = 1'b1;
    idle(1);
    for (int n = 30; n < 38; n++) begin
      send(good(n));
      chk("relock_locked_o", {79'd0, locked_o}, {79'd0, n == 37});
    end
    idle(2);

    // Valid toggled 1010: lock counts valid words only
    restart();
    for (int n = 40; n < 48; n++) begin
      send(good(n));
      chk("toggle_locked_o", {79'd0, locked_o}, {79'd0, n == 47});
      rx_data_i = good(99);
      idle(1);
      chk("toggle_gap_locked_o", {79'd0, locked_o}, {79'd0, n == 47});
    end
    exp_q.push_back(strip(good(48)));
    send(good(48));
    idle(2);

    // Swapped halves: offset 1, lock after 9th word, rejoined payload
    restart();
    for (int k = 60; k < 69; k++) begin
      send(raw_sw(k));
      chk("swap_locked_o", {79'd0, locked_o}, {79'd0, k == 68});
    end
    chk("swap_offset_o", {79'd0, offset_o}, 80'd1);
    for (int k = 69; k < 71; k++) begin
      exp_q.push_back(strip(good(k - 1)));
      send(raw_sw(k));
    end

    // Reset while locked: takes effect at that edge, no output emitted
    rst_n      = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = raw_sw(71);
    tick();
    chk("midrst_valid_o", {79'd0, valid_o}, '0);
    chk("midrst_locked_o", {79'd0, locked_o}, '0);
    chk("midrst_offset_o", {79'd0, offset_o}, '0);
    chk("midrst_err_cnt_o", {72'd0, err_cnt_o}, '0);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    chk("scoreboard_drained", 80'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aib_rx_word_aligner.md
AIB_RX_WORD_ALIGNER -- requirements
Module: aib_rx_word_aligner

Interface
REQ-001 The module SHALL have parameter LOCK_CNT, default 8, consecutive marker matches needed to lock (legal 2..255).
REQ-002 The module SHALL have parameter UNLOCK_CNT, default 4, consecutive marker misses needed to lose lock (legal 1..255).
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-005 Port align_en_i, input, 1: alignment enable; low forces IDLE.
REQ-006 Port rx_valid_i, input, 1: rx_data_i carries a word this cycle.
REQ-007 Port rx_data_i, input, 80: raw 2:1-mode word from the AIB channel (upper half [79:40], lower half [39:0]).
REQ-008 Port data_o, output, 78: aligned payload, markers stripped.
REQ-009 Port valid_o, output, 1: data_o valid this cycle.
REQ-010 Port locked_o, output, 1: alignment locked.
REQ-011 Port offset_o, output, 1: selected half-word offset (0 = as received, 1 = shifted by one half).
REQ-012 Port err_cnt_o, output, 8: saturating count of marker misses while locked.

Function
REQ-013 Candidate A SHALL be rx_data_i; candidate B SHALL be {rx_data_i[39:0], prev_q[79:40]}, where prev_q holds the last accepted word.
REQ-014 match(W) SHALL be W[79]==1 and W[39]==0.
REQ-015 prev_q SHALL update only when rx_valid_i=1; prev_ok SHALL set on the first accepted word after leaving IDLE and clear in IDLE.
REQ-016 Counters, state and markers SHALL be evaluated only on cycles with rx_valid_i=1; idle cycles SHALL change nothing.
REQ-017 FSM states SHALL be IDLE, SEARCH, VERIFY and LOCKED.
REQ-018 IDLE -> SEARCH on align_en_i=1.
REQ-019 SEARCH: match(A) -> VERIFY with offset 0 and hit_cnt=1; else match(B) with prev_ok=1 -> VERIFY with offset 1 and hit_cnt=1; A wins when both match.
REQ-020 VERIFY: match on the held offset -> hit_cnt+1, and -> LOCKED when the new value equals LOCK_CNT; miss -> SEARCH with hit_cnt=0.
REQ-021 LOCKED: match -> miss_cnt=0; miss -> miss_cnt+1 and err_cnt_o+1 (saturating at 255); when miss_cnt reaches UNLOCK_CNT -> SEARCH with miss_cnt=0.
REQ-022 offset_o SHALL change only on the SEARCH -> VERIFY transition.
REQ-023 align_en_i=0 in any state SHALL force IDLE on the next edge and clear hit_cnt, miss_cnt, prev_ok and err_cnt_o; this takes priority over all other transitions.
REQ-024 valid_o SHALL be asserted one cycle after an accepted word whose sampling state was LOCKED, except the word that completes the UNLOCK_CNT miss count; latency SHALL be exactly 1 cycle.
REQ-025 data_o SHALL be {W[78:40], W[38:0]} of the selected candidate, registered with valid_o, and SHALL hold its value while valid_o=0.
REQ-026 The word completing LOCK_CNT SHALL NOT be output; the first output word SHALL be the next accepted word.
REQ-027 locked_o SHALL be registered and equal to (state==LOCKED).

Reset
REQ-028 With rst_n=0 at an edge: state=IDLE; data_o=0, valid_o=0, locked_o=0, offset_o=0, err_cnt_o=0; prev_q=0; all counters and prev_ok = 0.
REQ-029 Reset asserted mid-VERIFY or mid-LOCKED SHALL take effect at that edge; no output word SHALL be emitted afterwards.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles with random rx traffic -> all outputs 0 and state IDLE.
REQ-031 Aligned stream (bit79=1, bit39=0, payload increments): locked_o=1 one cycle after the 8th valid word; offset_o=0; the 9th word appears on data_o one cycle later with markers stripped.
REQ-032 Swapped halves (bit79=0, bit39=1 in each raw word): offset_o=1; locked_o=1 one cycle after the 9th valid word; data_o equals the correctly rejoined half-words.
REQ-033 Same aligned stream with rx_valid_i toggled 1010...: the lock point occurs after the 8th valid word, not after 8 cycles; no spurious valid_o.
REQ-034 Locked, then 3 bad words followed by a good word: locked_o stays 1 and err_cnt_o=3. Then 4 consecutive bad words: locked_o falls one cycle after the 4th, err_cnt_o=7, and the 4th bad word is not output.
REQ-035 align_en_i dropped mid-VERIFY (hit_cnt=5), then re-raised: state passes through IDLE with err_cnt_o=0; relock requires a full 8 fresh matches.
